// File: rtl/poly_nco.sv
// Polyphonic NCO: VOICES phase accumulators evaluated one per cycle after each
// prescaler tick and summed into a registered mix sample with a TRIG strobe.
module poly_nco #(
   parameter int VOICES   = 4,
   parameter int PHASE_W  = 16,
   parameter int SAMPLE_W = 8,
   parameter int PRESCALE = 3125,
   localparam int VS_W    = (VOICES > 1) ? $clog2(VOICES) : 1,
   localparam int OUT_W   = SAMPLE_W + $clog2(VOICES)
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CE,
   input  logic                NOTE_ON,
   input  logic                NOTE_OFF,
   input  logic [VS_W-1:0]     VOICE_SEL,
   input  logic [PHASE_W-1:0]  STEP,
   input  logic [6:0]          VEL,
   input  logic [1:0]          WAVE,
   output logic [OUT_W-1:0]    SAMPLE_OUT,
   output logic                TRIG
);

   localparam int PS_W = $clog2(PRESCALE);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t state_q, state_d;
   logic [PS_W-1:0]  cnt_q, cnt_d;
   logic [VS_W-1:0]  idx_q, idx_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] sample_q, sample_d;

   logic [VOICES-1:0]              active_q, active_d;
   logic [VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
   logic [VOICES-1:0][PHASE_W-1:0] step_q, step_d;
   logic [VOICES-1:0][6:0]         vel_q, vel_d;
   logic [VOICES-1:0][1:0]         wave_q, wave_d;

   logic                  tick;
   logic [SAMPLE_W-1:0]   wave_s;
   logic [SAMPLE_W+6:0]   prod;
   logic [OUT_W-1:0]      contrib;

   function automatic logic [SAMPLE_W-1:0] wave_sample(input logic [1:0] w,
                                                       input logic [PHASE_W-1:0] p);
      logic [SAMPLE_W-1:0] s;
      unique case (w)
         2'b00:   s = p[PHASE_W-1 -: SAMPLE_W];
         2'b01:   s = {SAMPLE_W{p[PHASE_W-1]}};
         2'b10:   s = p[PHASE_W-1] ? ~p[PHASE_W-2 -: SAMPLE_W] : p[PHASE_W-2 -: SAMPLE_W];
         default: s = {SAMPLE_W{&p[PHASE_W-1 -: 2]}};
      endcase
      return s;
   endfunction

   assign tick = CE && (cnt_q == PS_W'(PRESCALE - 1));

   // Scaled contribution of the voice selected by idx; inactive voices add nothing.
   always_comb begin
      wave_s  = '0;
      prod    = '0;
      contrib = '0;
      for (int v = 0; v < VOICES; v++) begin
         if (idx_q == VS_W'(v) && active_q[v]) begin
            wave_s  = wave_sample(wave_q[v], phase_q[v]);
            prod    = {7'd0, wave_s} * {{SAMPLE_W{1'b0}}, vel_q[v]};
            contrib = OUT_W'(prod >> 7);
         end
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      sample_d = sample_q;
      active_d = active_q;
      phase_d  = phase_q;
      step_d   = step_q;
      vel_d    = vel_q;
      wave_d   = wave_q;

      if (CE) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = ACC;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         ACC: begin
            if (CE) begin
               acc_d = acc_q + contrib;
               if (idx_q == VS_W'(VOICES - 1)) begin
                  state_d  = DONE;
                  sample_d = acc_q + contrib;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
               for (int v = 0; v < VOICES; v++) begin
                  if (idx_q == VS_W'(v) && active_q[v]) begin
                     phase_d[v] = phase_q[v] + step_q[v];
                  end
               end
            end
         end
         DONE: begin
            if (CE) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Host writes come last so a NOTE_ON's phase clear beats a same-cycle increment.
      for (int v = 0; v < VOICES; v++) begin
         if (VOICE_SEL == VS_W'(v)) begin
            if (NOTE_ON) begin
               active_d[v] = 1'b1;
               phase_d[v]  = '0;
               step_d[v]   = STEP;
               vel_d[v]    = VEL;
               wave_d[v]   = WAVE;
            end else if (NOTE_OFF) begin
               active_d[v] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         sample_q <= '0;
         active_q <= '0;
         phase_q  <= '0;
         step_q   <= '0;
         vel_q    <= '0;
         wave_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         sample_q <= sample_d;
         active_q <= active_d;
         phase_q  <= phase_d;
         step_q   <= step_d;
         vel_q    <= vel_d;
         wave_q   <= wave_d;
      end
   end

   // TRIG is tied to the DONE state so a frozen DONE cycle never strobes twice.
   assign SAMPLE_OUT = sample_q;
   assign TRIG       = CE && (state_q == DONE);

endmodule

// File: doc/poly_nco.md
# poly_nco

Parametrised, polyphonic successor to the single-voice oscillator. Holds `VOICES` independent phase accumulators, each with its own step, velocity and waveform, and serially evaluates and mixes them once per sample period. Sits between MIDI voice allocation, which drives the NOTE_ON/NOTE_OFF writes, and the audio output stage, which consumes SAMPLE_OUT and TRIG.

## Interface
- `VOICES`, 4: number of voices, ≥2, need not be a power of two.
- `PHASE_W`, 16: phase accumulator and step width, ≥ SAMPLE_W+1.
- `SAMPLE_W`, 8: per-voice waveform width, unsigned.
- `PRESCALE`, 3125: CLK cycles per sample (32 kHz at 100 MHz); must be ≥ VOICES+2.
- `VS_W`, max(1,clog2(VOICES)): voice-select width (derived).
- `OUT_W`, SAMPLE_W+clog2(VOICES): mix width (derived).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CE` in 1: enables the prescaler and the mix FSM.
- `NOTE_ON` in 1: one-cycle write that starts voice VOICE_SEL.
- `NOTE_OFF` in 1: one-cycle write that stops voice VOICE_SEL.
- `VOICE_SEL` in VS_W: target voice of the write.
- `STEP` in PHASE_W: phase increment, latched on NOTE_ON.
- `VEL` in 7: velocity, latched on NOTE_ON.
- `WAVE` in 2: waveform, latched on NOTE_ON.
- `SAMPLE_OUT` out OUT_W: mixed sample, unsigned, registered.
- `TRIG` out 1: one-cycle pulse, new SAMPLE_OUT valid.

## Operation
- Per-voice registers: active, phase[PHASE_W], step, vel, wave.
- Reset: all voices inactive with zeroed registers, prescaler=0, FSM=IDLE, accumulator=0, SAMPLE_OUT=0, TRIG=0.
- Prescaler counts 0..PRESCALE-1 while CE=1 and wraps to 0. The tick is the cycle with count==PRESCALE-1 and CE=1.
- FSM states:
  - IDLE: goes to ACC on tick, with idx=0 and acc=0.
  - ACC: one voice per cycle. If idx==VOICES-1, go to DONE; else idx++.
  - DONE: SAMPLE_OUT<=acc, TRIG=1, then go to IDLE.
- Voice idx in ACC, using register values at cycle start:
  - Waveform sample s from phase p (msb = p[PHASE_W-1]):
    - 00 saw: p[PHASE_W-1 -: SAMPLE_W].
    - 01 square: all ones if msb else 0.
    - 10 triangle: t=p[PHASE_W-2 -: SAMPLE_W]; s = msb ? ~t : t.
    - 11 pulse 25%: all ones if p[PHASE_W-1:PHASE_W-2]==2'b11 else 0.
  - Contribution = (s*vel)>>7 if active, else 0. Maximum is 253 for SAMPLE_W=8. Added to acc.
  - If active, phase <= phase+step, modulo 2^PHASE_W (wraps silently).
- The sample for a frame uses the pre-increment phase. The first frame after NOTE_ON therefore samples phase 0.
- acc is OUT_W wide and never overflows.
- NOTE_ON: active=1, latch step/vel/wave, phase=0.
- NOTE_OFF: active=0. Phase and other registers are held.
- NOTE_ON and NOTE_OFF in the same cycle: NOTE_ON wins.
- VOICE_SEL ≥ VOICES: write ignored.
- Writes are accepted in any state, independent of CE.
- Write to a voice in the same cycle it is processed: the contribution uses the old registers, and the write's phase=0 overrides the increment. A voice already processed in this frame takes the write effect from the next frame.
- CE=0: prescaler, FSM, idx, acc and phases freeze. TRIG=0. SAMPLE_OUT holds.
- RST_N low at any time, including mid-frame: immediate return to reset values. No partial TRIG.

## Timing
- Tick in cycle t. Voice k is processed in cycle t+1+k.
- DONE occurs in cycle t+VOICES+1: SAMPLE_OUT updates at its start and TRIG is high for exactly that cycle.
- Tick-to-TRIG latency is VOICES+1 cycles. TRIG period is PRESCALE cycles with CE held high.
- First tick after reset release is at cycle PRESCALE-1 (CE=1 throughout).
- Write-to-effect: registers update on the edge ending the write cycle.

## Test plan
Benches 1–4 use VOICES=4, PHASE_W=16, SAMPLE_W=8, PRESCALE=16.
1. Reset: assert RST_N=0 during ACC -> SAMPLE_OUT=0 and TRIG=0 asynchronously. After release, first TRIG at cycle 16+4+1-1 from release.
2. Saw: NOTE_ON v0, STEP=0x1000, VEL=127, WAVE=00 -> successive SAMPLE_OUT 0, 15, 31, 47…, one TRIG every 16 cycles.
3. Square ×4: NOTE_ON v0..v3, STEP=0x8000, VEL=127, WAVE=01 -> SAMPLE_OUT alternates 0, 1012, 0, 1012.
4. Triangle: NOTE_ON v1, STEP=0x4000, VEL=127, WAVE=10 -> SAMPLE_OUT 0, 127, 253, 126, repeating. NOTE_OFF v1 -> 0 from the next frame. NOTE_ON again -> restarts at 0.
5. Edge cases: NOTE_ON and NOTE_OFF together -> voice active. VOICE_SEL=5 with VOICES=5, PRESCALE=16 -> ignored. NOTE_ON to the voice being processed -> phase=0 next frame.
6. CE low for 40 cycles mid-ACC -> no TRIG, SAMPLE_OUT held. Resume -> TRIG appears exactly the frozen remainder of cycles later.
